// File: rtl/simproc_control.sv
// simproc_control: multicycle control sequencer for the 8-bit simproc core.
// Fetches an instruction byte, holds it in an internal IR and sequences the
// register-file, ALU, memory and PC control strobes. No data passes through.
module simproc_control #(
   parameter bit RESET_TO_RUN = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] mem_rdata,
   input  logic       mem_ready,
   input  logic       flag_z,
   input  logic       flag_n,
   output logic       mem_read,
   output logic       mem_write,
   output logic       addr_sel,
   output logic       ir_load,
   output logic       pc_write,
   output logic       pc_src,
   output logic       RFWrite,
   output logic [1:0] regA,
   output logic [1:0] regB,
   output logic [1:0] regW,
   output logic       wb_sel,
   output logic [1:0] alu_op,
   output logic       flag_write,
   output logic       halted
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      HALT   = 3'd5
   } state_t;

   state_t     state;
   state_t     next_state;
   logic [7:0] ir;

   // Instruction fields
   logic [1:0] rx;
   logic [1:0] ry;
   logic [3:0] op;

   assign rx = ir[7:6];
   assign ry = ir[5:4];
   assign op = ir[3:0];

   // Opcode classification; the 3-bit ORI match wins over the 4-bit decode
   logic is_ori;
   logic is_load;
   logic is_store;
   logic is_add;
   logic is_sub;
   logic is_nand;
   logic is_alu;
   logic is_stop;
   logic is_bz;
   logic is_bnz;
   logic is_bpz;
   logic take_branch;

   assign is_ori   = (op[2:0] == 3'b111);
   assign is_load  = !is_ori && (op == 4'b0000);
   assign is_store = !is_ori && (op == 4'b0010);
   assign is_add   = !is_ori && (op == 4'b0100);
   assign is_sub   = !is_ori && (op == 4'b0110);
   assign is_nand  = !is_ori && (op == 4'b1000);
   assign is_stop  = !is_ori && (op == 4'b0001);
   assign is_bz    = !is_ori && (op == 4'b0101);
   assign is_bnz   = !is_ori && (op == 4'b1001);
   assign is_bpz   = !is_ori && (op == 4'b1101);
   assign is_alu   = is_add || is_sub || is_nand || is_ori;

   // Flags come straight from the datapath registers, so an ALU result from
   // the previous instruction is already visible when a branch reaches EXEC.
   assign take_branch = (is_bz  &&  flag_z) ||
                        (is_bnz && !flag_z) ||
                        (is_bpz && !flag_n);

   // ALU operation code for the decoded instruction
   function automatic logic [1:0] alu_code(input logic ori, input logic sub,
                                           input logic nand_op);
      logic [1:0] code;
      code = 2'b00;
      if (ori)
         code = 2'b11;
      else if (nand_op)
         code = 2'b10;
      else if (sub)
         code = 2'b01;
      return code;
   endfunction

   // State register; reset returns to IDLE immediately so all strobes drop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Instruction register, captured on the completing fetch cycle only
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         ir <= 8'h00;
      else if (ir_load)
         ir <= mem_rdata;
   end

   // Next-state and control-strobe decode from state, IR and handshake/flags
   always_comb begin
      next_state = state;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      addr_sel   = 1'b0;
      ir_load    = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      RFWrite    = 1'b0;
      regA       = 2'b00;
      regB       = 2'b00;
      regW       = 2'b00;
      wb_sel     = 1'b0;
      alu_op     = 2'b00;
      flag_write = 1'b0;
      halted     = 1'b0;

      case (state)
         IDLE: begin
            if (start || RESET_TO_RUN)
               next_state = FETCH;
         end

         FETCH: begin
            // Read at PC; outputs stay stable while memory stalls
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_load    = 1'b1;
               pc_write   = 1'b1;
               next_state = DECODE;
            end
         end

         DECODE: begin
            regA = is_ori ? 2'd1 : rx;
            regB = ry;
            if (is_stop)
               next_state = HALT;
            else if (is_load || is_store)
               next_state = MEM;
            else
               next_state = EXEC;
         end

         EXEC: begin
            regA = is_ori ? 2'd1 : rx;
            regB = ry;
            if (is_alu) begin
               RFWrite    = 1'b1;
               regW       = is_ori ? 2'd1 : rx;
               alu_op     = alu_code(is_ori, is_sub, is_nand);
               flag_write = 1'b1;
            end else if (take_branch) begin
               // PC already points past this instruction
               pc_write = 1'b1;
               pc_src   = 1'b1;
            end
            next_state = FETCH;
         end

         MEM: begin
            addr_sel = 1'b1;
            regB     = ry;
            if (is_load) begin
               mem_read = 1'b1;
               // Write back only when the data is actually present
               if (mem_ready) begin
                  RFWrite = 1'b1;
                  regW    = rx;
                  wb_sel  = 1'b1;
               end
            end else begin
               mem_write = 1'b1;
               regA      = rx;
            end
            if (mem_ready)
               next_state = FETCH;
         end

         HALT: begin
            halted = 1'b1;
         end

         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_simproc_control.sv
// Testbench for simproc_control: table of per-instruction expectations plus
// hand-written sequences for stalls, mid-instruction reset and HALT.
module tb_simproc_control;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] mem_rdata;
   logic       mem_ready;
   logic       flag_z;
   logic       flag_n;
   logic       mem_read;
   logic       mem_write;
   logic       addr_sel;
   logic       ir_load;
   logic       pc_write;
   logic       pc_src;
   logic       RFWrite;
   logic [1:0] regA;
   logic [1:0] regB;
   logic [1:0] regW;
   logic       wb_sel;
   logic [1:0] alu_op;
   logic       flag_write;
   logic       halted;

   simproc_control dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .flag_z     (flag_z),
      .flag_n     (flag_n),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .addr_sel   (addr_sel),
      .ir_load    (ir_load),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .RFWrite    (RFWrite),
      .regA       (regA),
      .regB       (regB),
      .regW       (regW),
      .wb_sel     (wb_sel),
      .alu_op     (alu_op),
      .flag_write (flag_write),
      .halted     (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       mr;
      logic       mw;
      logic       as;
      logic       il;
      logic       pw;
      logic       ps;
      logic       rf;
      logic [1:0] ra;
      logic [1:0] rb;
      logic [1:0] rw;
      logic       wb;
      logic [1:0] op;
      logic       fw;
      logic       h;
   } ctrl_t;

   typedef struct {
      string      name;
      logic [7:0] instr;
      logic       fz;
      logic       fn;
      ctrl_t      dec;
      ctrl_t      exe;
   } vec_t;

   ctrl_t act;
   assign act = {mem_read, mem_write, addr_sel, ir_load, pc_write, pc_src,
                 RFWrite, regA, regB, regW, wb_sel, alu_op, flag_write, halted};

   int    errors = 0;
   int    checks = 0;
   ctrl_t exp_q[$];
   string name_q[$];
   vec_t  vecs[16];

   function automatic ctrl_t cw(logic mr, logic mw, logic as, logic il,
                                logic pw, logic ps, logic rf,
                                logic [1:0] ra, logic [1:0] rb, logic [1:0] rw,
                                logic wb, logic [1:0] op, logic fw, logic h);
      ctrl_t c;
      c = {mr, mw, as, il, pw, ps, rf, ra, rb, rw, wb, op, fw, h};
      return c;
   endfunction

   task automatic compare(input string name, input ctrl_t got, input ctrl_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %05h expected %05h (mr mw as il pw ps rf ra rb rw wb op fw h)",
                  name, got, exp);
      end
   endtask

   task automatic expect_word(input string name, input ctrl_t exp);
      exp_q.push_back(exp);
      name_q.push_back(name);
   endtask

   // Sample mid-cycle, pop the oldest expectation, then advance past the edge
   task automatic check_cycle();
      ctrl_t e;
      string n;
      @(negedge clk);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: got empty queue required an entry");
      end else begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         compare(n, act, e);
      end
      @(posedge clk);
      #1;
   endtask

   ctrl_t W0, WFETCH, WFSTALL, WHALT;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      W0      = '0;
      WFETCH  = cw(1,0,0,1,1,0,0, 0,0,0, 0,0,0,0);
      WFSTALL = cw(1,0,0,0,0,0,0, 0,0,0, 0,0,0,0);
      WHALT   = cw(0,0,0,0,0,0,0, 0,0,0, 0,0,0,1);

      //                name        instr  fz fn  decode word                         exec/mem word
      vecs[0]  = '{"add_14",   8'h14, 0, 0, cw(0,0,0,0,0,0,0, 0,1,0, 0,0,0,0), cw(0,0,0,0,0,0,1, 0,1,0, 0,0,1,0)};
      vecs[1]  = '{"sub_96",   8'h96, 0, 0, cw(0,0,0,0,0,0,0, 2,1,0, 0,0,0,0), cw(0,0,0,0,0,0,1, 2,1,2, 0,1,1,0)};
      vecs[2]  = '{"nand_e8",  8'hE8, 1, 1, cw(0,0,0,0,0,0,0, 3,2,0, 0,0,0,0), cw(0,0,0,0,0,0,1, 3,2,3, 0,2,1,0)};
      vecs[3]  = '{"ori_ff",   8'hFF, 0, 0, cw(0,0,0,0,0,0,0, 1,3,0, 0,0,0,0), cw(0,0,0,0,0,0,1, 1,3,1, 0,3,1,0)};
      vecs[4]  = '{"ori_37",   8'h37, 0, 0, cw(0,0,0,0,0,0,0, 1,3,0, 0,0,0,0), cw(0,0,0,0,0,0,1, 1,3,1, 0,3,1,0)};
      vecs[5]  = '{"bz_tk",    8'hF5, 1, 0, cw(0,0,0,0,0,0,0, 3,3,0, 0,0,0,0), cw(0,0,0,0,1,1,0, 3,3,0, 0,0,0,0)};
      vecs[6]  = '{"bz_nt",    8'hF5, 0, 1, cw(0,0,0,0,0,0,0, 3,3,0, 0,0,0,0), cw(0,0,0,0,0,0,0, 3,3,0, 0,0,0,0)};
      vecs[7]  = '{"bnz_tk",   8'h09, 0, 1, cw(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0), cw(0,0,0,0,1,1,0, 0,0,0, 0,0,0,0)};
      vecs[8]  = '{"bnz_nt",   8'h09, 1, 0, cw(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0), cw(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0)};
      vecs[9]  = '{"bpz_tk",   8'h4D, 1, 0, cw(0,0,0,0,0,0,0, 1,0,0, 0,0,0,0), cw(0,0,0,0,1,1,0, 1,0,0, 0,0,0,0)};
      vecs[10] = '{"bpz_nt",   8'h4D, 0, 1, cw(0,0,0,0,0,0,0, 1,0,0, 0,0,0,0), cw(0,0,0,0,0,0,0, 1,0,0, 0,0,0,0)};
      vecs[11] = '{"nop_03",   8'h03, 1, 1, cw(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0), cw(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0)};
      vecs[12] = '{"nop_0a",   8'h0A, 0, 0, cw(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0), cw(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0)};
      vecs[13] = '{"nop_0e",   8'h0E, 0, 0, cw(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0), cw(0,0,0,0,0,0,0, 0,0,0, 0,0,0,0)};
      vecs[14] = '{"load_60",  8'h60, 0, 0, cw(0,0,0,0,0,0,0, 1,2,0, 0,0,0,0), cw(1,0,1,0,0,0,1, 0,2,1, 1,0,0,0)};
      vecs[15] = '{"store_b2", 8'hB2, 0, 0, cw(0,0,0,0,0,0,0, 2,3,0, 0,0,0,0), cw(0,1,1,0,0,0,0, 2,3,0, 0,0,0,0)};

      rst       = 1'b0;
      start     = 1'b1;
      mem_rdata = 8'h00;
      mem_ready = 1'b1;
      flag_z    = 1'b0;
      flag_n    = 1'b0;
      @(posedge clk);
      #1;

      // Held in reset with start high: everything quiet
      expect_word("reset_0", W0);
      check_cycle();
      expect_word("reset_1", W0);
      check_cycle();

      // Released with start low: stays IDLE
      start = 1'b0;
      rst   = 1'b1;
      expect_word("idle_0", W0);
      check_cycle();
      expect_word("idle_1", W0);
      check_cycle();
      start = 1'b1;
      expect_word("idle_start", W0);
      check_cycle();
      start = 1'b0;

      // Table: FETCH, DECODE, EXEC/MEM for each instruction with mem_ready = 1
      for (int i = 0; i < 16; i++) begin
         mem_rdata = vecs[i].instr;
         mem_ready = 1'b1;
         flag_z    = vecs[i].fz;
         flag_n    = vecs[i].fn;
         expect_word({vecs[i].name, "_fetch"}, WFETCH);
         expect_word({vecs[i].name, "_decode"}, vecs[i].dec);
         expect_word({vecs[i].name, "_exec"}, vecs[i].exe);
         for (int c = 0; c < 3; c++)
            check_cycle();
      end

      // Fetch stall then LOAD with two MEM wait cycles
      mem_ready = 1'b0;
      mem_rdata = 8'h00;
      expect_word("fstall_0", WFSTALL);
      check_cycle();
      expect_word("fstall_1", WFSTALL);
      check_cycle();
      mem_ready = 1'b1;
      mem_rdata = 8'h60;
      expect_word("ld_fetch", WFETCH);
      check_cycle();
      mem_rdata = 8'h00;
      expect_word("ld_decode", cw(0,0,0,0,0,0,0, 1,2,0, 0,0,0,0));
      check_cycle();
      mem_ready = 1'b0;
      expect_word("ld_wait_0", cw(1,0,1,0,0,0,0, 0,2,0, 0,0,0,0));
      check_cycle();
      expect_word("ld_wait_1", cw(1,0,1,0,0,0,0, 0,2,0, 0,0,0,0));
      check_cycle();
      mem_ready = 1'b1;
      expect_word("ld_done", cw(1,0,1,0,0,0,1, 0,2,1, 1,0,0,0));
      check_cycle();

      // STORE interrupted by reset during MEM
      mem_rdata = 8'hB2;
      expect_word("st_fetch", WFETCH);
      check_cycle();
      expect_word("st_decode", cw(0,0,0,0,0,0,0, 2,3,0, 0,0,0,0));
      check_cycle();
      mem_ready = 1'b0;
      expect_word("st_wait", cw(0,1,1,0,0,0,0, 2,3,0, 0,0,0,0));
      check_cycle();
      #2;
      rst = 1'b0;
      #1;
      compare("st_async_reset", act, W0);
      @(posedge clk);
      #1;
      compare("st_reset_held", act, W0);
      start     = 1'b0;
      mem_ready = 1'b1;
      rst       = 1'b1;
      expect_word("st_after_0", W0);
      check_cycle();
      expect_word("st_after_1", W0);
      check_cycle();

      // Restart and run STOP into HALT
      start = 1'b1;
      expect_word("restart", W0);
      check_cycle();
      start     = 1'b0;
      mem_rdata = 8'h01;
      expect_word("stop_fetch", WFETCH);
      check_cycle();
      expect_word("stop_decode", W0);
      check_cycle();
      for (int k = 0; k < 5; k++) begin
         start     = k[0];
         mem_ready = ~k[0];
         flag_z    = k[1];
         expect_word($sformatf("halt_%0d", k), WHALT);
         check_cycle();
      end

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
